// File: rtl/arb_puf_axil_ctrl.sv
// arb_puf_axil_ctrl: AXI4-Lite control stage that launches arbiter-PUF evaluations and latches responses
module arb_puf_axil_ctrl #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4,
  parameter int C_CHAL_W           = 16,
  parameter int C_RESP_W           = 4,
  parameter int C_TIMEOUT          = 255
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic [C_CHAL_W-1:0]             puf_challenge,
  output logic                            puf_start,
  input  logic                            puf_done,
  input  logic [C_RESP_W-1:0]             puf_response
);
  localparam int CW = $clog2(C_TIMEOUT + 1);
  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT} state_t;
  state_t state_q;
  logic awready_q, bvalid_q, arready_q, rvalid_q, start_q, done_q, tmo_q;
  logic [C_S_AXI_DATA_WIDTH-1:0] rdata_q, rdata_d, wmask;
  logic [C_CHAL_W-1:0] chal_q, chal_d, pchal_q;
  logic [C_RESP_W-1:0] resp_q;
  logic [CW-1:0] cnt_q;
  logic wr_ctrl, wr_chal, go, clr, busy, unused;
  assign busy    = state_q != S_IDLE;
  assign wr_ctrl = awready_q && S_AXI_AWADDR[3:2] == 2'd0;
  assign wr_chal = awready_q && S_AXI_AWADDR[3:2] == 2'd1 && !busy;
  assign go      = wr_ctrl && S_AXI_WDATA[0] && !busy;
  assign clr     = wr_ctrl && S_AXI_WDATA[1];
  always_comb begin
    wmask   = {{8{S_AXI_WSTRB[3]}}, {8{S_AXI_WSTRB[2]}}, {8{S_AXI_WSTRB[1]}}, {8{S_AXI_WSTRB[0]}}};
    chal_d  = wr_chal ? (chal_q & ~wmask[C_CHAL_W-1:0]) | (S_AXI_WDATA[C_CHAL_W-1:0] & wmask[C_CHAL_W-1:0]) : chal_q;
    rdata_d = S_AXI_ARADDR[3:2] == 2'd1 ? C_S_AXI_DATA_WIDTH'(chal_q) :
              S_AXI_ARADDR[3:2] == 2'd2 ? C_S_AXI_DATA_WIDTH'({tmo_q, done_q, busy}) :
              S_AXI_ARADDR[3:2] == 2'd3 ? C_S_AXI_DATA_WIDTH'(resp_q) : '0;
  end
  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      state_q   <= S_IDLE;
      awready_q <= 1'b0;
      bvalid_q  <= 1'b0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      start_q   <= 1'b0;
      done_q    <= 1'b0;
      tmo_q     <= 1'b0;
      chal_q    <= '0;
      pchal_q   <= '0;
      resp_q    <= '0;
      cnt_q     <= '0;
    end else begin
      awready_q <= S_AXI_AWVALID && S_AXI_WVALID && !bvalid_q && !awready_q;
      arready_q <= S_AXI_ARVALID && !rvalid_q && !arready_q;
      bvalid_q  <= awready_q || (bvalid_q && !S_AXI_BREADY);
      rvalid_q  <= arready_q || (rvalid_q && !S_AXI_RREADY);
      rdata_q   <= arready_q ? rdata_d : rdata_q;
      chal_q    <= chal_d;
      start_q   <= go;
      if (clr || go) begin
        done_q <= 1'b0;
        tmo_q  <= 1'b0;
      end
      // completion updates follow the CLR clear so a finishing evaluation always posts its flag
      case (state_q)
        S_IDLE: if (go) begin
          state_q <= S_LAUNCH;
          pchal_q <= chal_q;
        end
        S_LAUNCH: begin
          cnt_q   <= '0;
          state_q <= S_WAIT;
        end
        S_WAIT: if (puf_done) begin
          resp_q  <= puf_response;
          done_q  <= 1'b1;
          state_q <= S_IDLE;
        end else if (cnt_q == CW'(C_TIMEOUT - 1)) begin
          tmo_q   <= 1'b1;
          state_q <= S_IDLE;
        end else cnt_q <= cnt_q + 1'b1;
        default: state_q <= S_IDLE;
      endcase
    end
  end
  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = awready_q;
  assign S_AXI_BRESP   = 2'b00;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = 2'b00;
  assign S_AXI_RVALID  = rvalid_q;
  assign puf_challenge = pchal_q;
  assign puf_start     = start_q;
  assign unused = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0],
                    S_AXI_WDATA[C_S_AXI_DATA_WIDTH-1:C_CHAL_W], wmask[C_S_AXI_DATA_WIDTH-1:C_CHAL_W]};
endmodule

// File: tb/tb_arb_puf_axil_ctrl.sv
// tb_arb_puf_axil_ctrl: scoreboard bench driving AXI-Lite transactions and a behavioural PUF core
module tb_arb_puf_axil_ctrl;
  logic clk = 1'b0, rstn = 1'b0;
  always #5 clk = ~clk;
  logic [3:0] awaddr = '0, araddr = '0, wstrb = '0, puf_response = '0;
  logic [31:0] wdata = '0;
  logic awvalid = 0, wvalid = 0, bready = 1, arvalid = 0, rready = 1, puf_done = 0;
  logic [2:0] prot = '0;
  logic awready, wready, bvalid, arready, rvalid, puf_start;
  logic [1:0] bresp, rresp;
  logic [31:0] rdata;
  logic [15:0] puf_challenge;
  arb_puf_axil_ctrl dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rstn),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(prot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(prot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .puf_challenge(puf_challenge), .puf_start(puf_start), .puf_done(puf_done), .puf_response(puf_response)
  );
  typedef struct {logic [31:0] v; string n;} exp_t;
  exp_t rq[$];
  exp_t me;
  logic [15:0] sq[$];
  logic [1:0] bq[$];
  int compared = 0, mism = 0, cyc = 0, start_cyc = 0;
  logic sp = 0, core_en = 1;
  int core_delay = 7;
  logic [3:0] core_resp = '0;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    compared++;
    if (a !== e) begin
      mism++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", n, a, e);
    end
  endtask
  task automatic flag(input string n);
    compared++;
    mism++;
    $display("FAIL %s", n);
  endtask
  task automatic push_r(input logic [31:0] v, input string n);
    exp_t e;
    e.v = v;
    e.n = n;
    rq.push_back(e);
  endtask
  task automatic wait_aw(input string n);
    int k = 0;
    do begin @(negedge clk); k++; end while (!awready && k < 50);
    if (!awready) flag({n, " timeout"});
    @(posedge clk); #1;
    awvalid = 0;
    wvalid = 0;
  endtask
  task automatic wait_b(input string n);
    int k = 0;
    do begin @(negedge clk); k++; end while (!(bvalid && bready) && k < 50);
    if (!(bvalid && bready)) flag({n, " timeout"});
    @(posedge clk); #1;
  endtask
  task automatic wait_ar(input string n);
    int k = 0;
    do begin @(negedge clk); k++; end while (!arready && k < 50);
    if (!arready) flag({n, " timeout"});
    @(posedge clk); #1;
    arvalid = 0;
  endtask
  task automatic wait_r(input string n);
    int k = 0;
    do begin @(negedge clk); k++; end while (!(rvalid && rready) && k < 50);
    if (!(rvalid && rready)) flag({n, " timeout"});
    @(posedge clk); #1;
  endtask
  task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s = 4'hF);
    awaddr = a; wdata = d; wstrb = s; awvalid = 1; wvalid = 1;
    bq.push_back(2'b00);
    wait_aw("aw");
    wait_b("b");
  endtask
  task automatic rd(input logic [3:0] a, input logic [31:0] e, input string n);
    push_r(e, n);
    araddr = a; arvalid = 1;
    wait_ar({n, " ar"});
    wait_r({n, " r"});
  endtask
  always @(negedge clk) begin
    cyc++;
    if (!rstn) sp = 0;
    else begin
      if (rvalid && rready) begin
        if (rq.size() == 0) flag("unexpected read response");
        else begin
          me = rq.pop_front();
          chk(me.n, rdata, me.v);
          chk("rresp", 32'(rresp), 32'd0);
        end
      end
      if (bvalid && bready) begin
        if (bq.size() == 0) flag("unexpected write response");
        else chk("bresp", 32'(bresp), 32'(bq.pop_front()));
      end
      if (puf_start) begin
        if (sp) flag("puf_start wider than one cycle");
        if (sq.size() == 0) flag("unexpected puf_start");
        else chk("challenge", 32'(puf_challenge), 32'(sq.pop_front()));
        start_cyc = cyc;
      end
      sp = puf_start;
    end
  end
  initial forever begin
    @(negedge clk);
    if (puf_start && core_en) begin
      repeat (core_delay) @(posedge clk);
      #1 puf_done = 1; puf_response = core_resp;
      @(posedge clk); #1 puf_done = 0;
    end
  end
  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    int k;
    repeat (3) @(posedge clk);
    #1 rstn = 1;
    @(negedge clk);
    chk("rst awready", 32'(awready), 0);
    chk("rst wready", 32'(wready), 0);
    chk("rst bvalid", 32'(bvalid), 0);
    chk("rst arready", 32'(arready), 0);
    chk("rst rvalid", 32'(rvalid), 0);
    chk("rst rdata", rdata, 0);
    chk("rst puf_start", 32'(puf_start), 0);
    chk("rst challenge", 32'(puf_challenge), 0);
    @(posedge clk); #1;
    wr(4, 32'h0000A5C3);
    rd(4, 32'h0000A5C3, "chal readback");
    wr(4, 32'h0000FFFF, 4'b0001);
    rd(4, 32'h0000A5FF, "chal byte strobe");
    wr(4, 32'h12345678);
    rd(4, 32'h00005678, "chal upper bits");
    wr(8, 32'h7);
    rd(8, 0, "stat read-only");
    wr(12, 32'hF);
    rd(12, 0, "resp read-only");
    rd(0, 0, "ctrl reads zero");
    core_delay = 7; core_resp = 4'hB;
    wr(4, 32'h1234);
    sq.push_back(16'h1234);
    wr(0, 1);
    rd(8, 1, "stat busy");
    repeat (12) @(posedge clk); #1;
    rd(8, 2, "stat done");
    rd(12, 32'hB, "resp done");
    core_en = 0;
    wr(4, 32'h00F0);
    sq.push_back(16'h00F0);
    wr(0, 3);
    k = 0;
    do begin @(posedge clk); k++; end while (cyc != start_cyc + 253 && k < 400);
    #1;
    rd(8, 1, "stat last wait cycle");
    rd(8, 4, "stat timeout");
    rd(12, 32'hB, "resp kept on timeout");
    wr(0, 2);
    rd(8, 0, "stat after clr");
    core_en = 1; core_delay = 40; core_resp = 4'h5;
    wr(4, 32'h0A0A);
    sq.push_back(16'h0A0A);
    wr(0, 1);
    wr(4, 32'hFFFF);
    wr(0, 1);
    chk("challenge stable", 32'(puf_challenge), 32'h0A0A);
    rd(8, 1, "stat busy2");
    repeat (50) @(posedge clk); #1;
    rd(8, 2, "stat done2");
    rd(12, 32'h5, "resp done2");
    rd(4, 32'h0A0A, "chal write ignored");
    bready = 0;
    awaddr = 4; wdata = 32'h55; wstrb = 4'hF; awvalid = 1; wvalid = 1;
    bq.push_back(2'b00);
    wait_aw("aw hold1");
    wdata = 32'h77; awvalid = 1; wvalid = 1;
    bq.push_back(2'b00);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bvalid held", 32'(bvalid), 1);
      chk("aw blocked", 32'(awready), 0);
    end
    @(posedge clk); #1 bready = 1;
    wait_b("b hold1");
    wait_aw("aw hold2");
    wait_b("b hold2");
    rd(4, 32'h77, "chal after b hold");
    rready = 0;
    push_r(32'h77, "r held data");
    araddr = 4; arvalid = 1;
    wait_ar("ar hold1");
    push_r(32'h2, "r after hold");
    araddr = 8; arvalid = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("rvalid held", 32'(rvalid), 1);
      chk("rdata held", rdata, 32'h77);
      chk("ar blocked", 32'(arready), 0);
    end
    @(posedge clk); #1 rready = 1;
    wait_r("r hold1");
    wait_ar("ar hold2");
    wait_r("r hold2");
    core_delay = 20; core_resp = 4'hE;
    wr(4, 32'h0C0C);
    sq.push_back(16'h0C0C);
    wr(0, 1);
    repeat (4) @(posedge clk);
    #1 rstn = 0;
    @(posedge clk); #1 rstn = 1;
    @(negedge clk);
    chk("rst2 challenge", 32'(puf_challenge), 0);
    chk("rst2 puf_start", 32'(puf_start), 0);
    chk("rst2 bvalid", 32'(bvalid), 0);
    chk("rst2 rvalid", 32'(rvalid), 0);
    chk("rst2 rdata", rdata, 0);
    repeat (30) @(posedge clk); #1;
    rd(8, 0, "stat after reset");
    rd(12, 0, "resp after reset");
    rd(4, 0, "chal after reset");
    core_delay = 5; core_resp = 4'h6;
    wr(4, 32'h00C0);
    sq.push_back(16'h00C0);
    wr(0, 1);
    repeat (12) @(posedge clk); #1;
    rd(8, 2, "stat done3");
    rd(12, 32'h6, "resp done3");
    repeat (3) @(posedge clk);
    chk("read queue drained", rq.size(), 0);
    chk("write queue drained", bq.size(), 0);
    chk("start queue drained", sq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
    $finish;
  end
endmodule
